// File: rtl/four_bank_mem_pkg.sv
// Shared constants for the banked main memory and the cache controller
// upstream of it: address slicing, default timing, and the read-return
// pipeline stage type.
package four_bank_mem_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int NUM_BANKS     = 4;
    localparam int BANK_BITS     = 2;
    localparam int BANK_LSB      = 1;   // Addr[2:1] selects the bank
    localparam int ROW_LSB       = 3;   // Addr[15:3] selects the row
    localparam int ROW_BITS_DEF  = 13;
    localparam int RD_LAT_DEF    = 2;
    localparam int BANK_BUSY_DEF = 4;
    localparam int BUSY_CNT_W    = 3;

    // One stage of the read-return pipeline.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

endpackage

// File: rtl/four_bank_mem_bank.sv
// One memory bank: word storage, write port and the busy-window counter
// that spaces accesses to this bank BANK_BUSY cycles apart.
module mem_bank
    import four_bank_mem_pkg::*;
#(
    parameter int ROW_BITS  = ROW_BITS_DEF,
    parameter int BANK_BUSY = BANK_BUSY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                accept,
    input  logic                wr,
    input  logic [ROW_BITS-1:0] row,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy
);

    localparam int DEPTH = 1 << ROW_BITS;
    localparam logic [BUSY_CNT_W-1:0] BUSY_LOAD = BUSY_CNT_W'(BANK_BUSY - 1);

    // Contents start at zero at power-up only; reset never touches them.
    logic [DATA_W-1:0]     mem_array [DEPTH] = '{default: '0};
    logic [BUSY_CNT_W-1:0] busy_cnt;

    // Busy window: load on acceptance, count down to idle otherwise.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (accept) begin
            busy_cnt <= BUSY_LOAD;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // Write port; the array is outside the reset branch.
    // NOTE: memories are not reset -- a reset loop would turn the RAM into
    // flops, and writes made before a reset must survive it.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem_array[row] <= wdata;
        end
    end

    assign rdata = mem_array[row];
    assign busy  = (busy_cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Four word-interleaved banks behind a single request port. Decodes the
// target bank, raises stall/err, and returns read data through a shared
// RD_LAT-deep pipeline (at most one read accepted per cycle).
module four_bank_mem
    import four_bank_mem_pkg::*;
#(
    parameter int ROW_BITS  = ROW_BITS_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int BANK_BUSY = BANK_BUSY_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    Addr,
    input  logic [DATA_W-1:0]    DataIn,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    DataOut,
    output logic                 rd_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    logic [BANK_BITS-1:0] bank_sel;
    logic [ROW_BITS-1:0]  row_sel;
    logic                 request;
    logic                 accept;
    logic [NUM_BANKS-1:0] bank_accept;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0]    sel_rdata;
    rd_stage_t            rd_pipe [RD_LAT];

    assign bank_sel = Addr[BANK_LSB +: BANK_BITS];
    assign row_sel  = Addr[ROW_LSB +: ROW_BITS];

    // A legal request is exactly one of rd/wr to a word-aligned address.
    assign request = (rd ^ wr) & ~Addr[0];
    assign stall   = request & busy[bank_sel];
    assign accept  = request & ~busy[bank_sel] & ~rst;
    assign err     = (rd & wr) | ((rd | wr) & Addr[0]);

    // Route the acceptance strobe to the addressed bank and pick its read data.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        bank_accept           = '0;
        bank_accept[bank_sel] = accept;
        sel_rdata             = bank_rdata[bank_sel];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .ROW_BITS  (ROW_BITS),
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .accept (bank_accept[b]),
            .wr     (wr),
            .row    (row_sel),
            .wdata  (DataIn),
            .rdata  (bank_rdata[b]),
            .busy   (busy[b])
        );
    end

    // Read-return pipeline: the array is sampled at acceptance and emerges
    // RD_LAT cycles later; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= '{valid: accept & rd, data: sel_rdata};
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_valid = rd_pipe[RD_LAT-1].valid;
    assign DataOut  = rd_pipe[RD_LAT-1].valid ? rd_pipe[RD_LAT-1].data : '0;

endmodule

// File: tb/tb_four_bank_mem.sv
// Self-checking bench for four_bank_mem: a table of hand-derived cycle
// vectors covering the directed scenarios, then randomized traffic compared
// against a time-based reference model (per-bank last-acceptance time,
// a word-addressed memory map and a queue of scheduled read returns).
module tb_four_bank_mem;

    localparam int RD_LAT    = 2;
    localparam int BANK_BUSY = 4;
    localparam int N_RAND    = 2000;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] din;
    logic        wr;
    logic        rd;
    logic [15:0] dout;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    four_bank_mem #(
        .ROW_BITS  (13),
        .RD_LAT    (RD_LAT),
        .BANK_BUSY (BANK_BUSY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (addr),
        .DataIn   (din),
        .wr       (wr),
        .rd       (rd),
        .DataOut  (dout),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    int          last_acc [4];
    ret_t        ret_q [$];
    logic [15:0] ref_mem [int];
    bit          exp_stall_last;

    function automatic logic [15:0] mem_rd(input int word);
        if (ref_mem.exists(word)) return ref_mem[word];
        return 16'h0000;
    endfunction

    // Evaluates expected outputs for the current cycle, optionally compares
    // them, then advances the model across the coming clock edge.
    task automatic model_step(input logic r, input logic rdv, input logic wrv,
                              input logic [15:0] a, input logic [15:0] d,
                              input bit do_check);
        int          bk;
        bit          is_req;
        logic [3:0]  bexp;
        logic        e_stall;
        logic        e_err;
        logic        e_valid;
        logic [15:0] e_dout;
        bk     = int'(a[2:1]);
        is_req = (rdv ^ wrv) && !a[0];
        for (int i = 0; i < 4; i++) begin
            bexp[i] = (cyc - last_acc[i] >= 1) && (cyc - last_acc[i] <= BANK_BUSY - 1);
        end
        e_stall = is_req && bexp[bk];
        e_err   = (rdv && wrv) || ((rdv || wrv) && a[0]);
        e_valid = 1'b0;
        e_dout  = 16'h0000;
        foreach (ret_q[i]) begin
            if (ret_q[i].due == cyc) begin
                e_valid = 1'b1;
                e_dout  = ret_q[i].data;
            end
        end
        exp_stall_last = e_stall;
        if (do_check) begin
            check("rand stall",    32'(stall),    32'(e_stall));
            check("rand err",      32'(err),      32'(e_err));
            check("rand busy",     32'(busy),     32'(bexp));
            check("rand rd_valid", 32'(rd_valid), 32'(e_valid));
            check("rand DataOut",  32'(dout),     32'(e_dout));
        end
        while (ret_q.size() > 0 && ret_q[0].due <= cyc) void'(ret_q.pop_front());
        if (r) begin
            for (int i = 0; i < 4; i++) last_acc[i] = -1000;
            ret_q.delete();
        end else if (is_req && !bexp[bk]) begin
            last_acc[bk] = cyc;
            if (wrv) ref_mem[int'(a[15:1])] = d;
            else     ret_q.push_back('{due: cyc + RD_LAT, data: mem_rd(int'(a[15:1]))});
        end
    endtask

    // Drive inputs just after an edge; outputs are then sampled mid-cycle.
    task automatic drive(input logic r, input logic rdv, input logic wrv,
                         input logic [15:0] a, input logic [15:0] d);
        rst  = r;
        rd   = rdv;
        wr   = wrv;
        addr = a;
        din  = d;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic        rdv;
        logic        wrv;
        logic [15:0] a;
        logic [15:0] d;
        logic        e_stall;
        logic        e_err;
        logic [3:0]  e_busy;
        logic        e_valid;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic rdv, input logic wrv,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic st, input logic er, input logic [3:0] bz,
                                input logic v, input logic [15:0] o);
        vec_t t;
        t.r = r; t.rdv = rdv; t.wrv = wrv; t.a = a; t.d = d;
        t.e_stall = st; t.e_err = er; t.e_busy = bz; t.e_valid = v; t.e_dout = o;
        return t;
    endfunction

    function automatic vec_t idle(input logic [3:0] bz, input logic v, input logic [15:0] o);
        return mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, bz, v, o);
    endfunction

    initial begin
        logic        r_r, r_rd, r_wr;
        logic [15:0] r_a, r_d;

        for (int i = 0; i < 4; i++) last_acc[i] = -1000;
        exp_stall_last = 1'b0;

        // Reset-state check and write/read round trip at 0x0010.
        vecs.push_back(idle(4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 1, 16'hBEEF));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        // Preload 1..4 into all four banks on consecutive cycles.
        vecs.push_back(mk(0, 0, 1, 16'h0100, 16'h0001, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h0102, 16'h0002, 0, 0, 4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h0104, 16'h0003, 0, 0, 4'b0011, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h0106, 16'h0004, 0, 0, 4'b0111, 0, 16'h0000));
        vecs.push_back(idle(4'b1110, 0, 16'h0000));
        vecs.push_back(idle(4'b1100, 0, 16'h0000));
        vecs.push_back(idle(4'b1000, 0, 16'h0000));
        // Back-to-back reads across banks return in order.
        vecs.push_back(mk(0, 1, 0, 16'h0100, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0102, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0104, 16'h0000, 0, 0, 4'b0011, 1, 16'h0001));
        vecs.push_back(mk(0, 1, 0, 16'h0106, 16'h0000, 0, 0, 4'b0111, 1, 16'h0002));
        vecs.push_back(idle(4'b1110, 1, 16'h0003));
        vecs.push_back(idle(4'b1100, 1, 16'h0004));
        vecs.push_back(idle(4'b1000, 0, 16'h0000));
        // Same-bank conflict: three stall cycles, accepted on the fourth.
        vecs.push_back(mk(0, 0, 1, 16'h0020, 16'h5A5A, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0028, 16'h0000, 1, 0, 4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0028, 16'h0000, 1, 0, 4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0028, 16'h0000, 1, 0, 4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0028, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 1, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        // Illegal requests: no access, no busy, no stall.
        vecs.push_back(mk(0, 1, 1, 16'h0040, 16'hDEAD, 0, 1, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0041, 16'h0000, 0, 1, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h0041, 16'hDEAD, 0, 1, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0040, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 1, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        // Reset with a read in flight and a write presented during reset.
        vecs.push_back(mk(0, 0, 1, 16'h0060, 16'h1234, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0001, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0062, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 1, 16'h0004, 16'hFFFF, 0, 0, 4'b0010, 0, 16'h0000));
        vecs.push_back(idle(4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0060, 16'h0000, 0, 0, 4'b0000, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 16'h0004, 16'h0000, 0, 0, 4'b0001, 0, 16'h0000));
        vecs.push_back(idle(4'b0101, 1, 16'h1234));
        vecs.push_back(idle(4'b0101, 1, 16'h0000));
        vecs.push_back(idle(4'b0100, 0, 16'h0000));
        vecs.push_back(idle(4'b0000, 0, 16'h0000));

        // Power-up reset.
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].rdv, vecs[i].wrv, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d stall", i),    32'(stall),    32'(vecs[i].e_stall));
            check($sformatf("vec%0d err", i),      32'(err),      32'(vecs[i].e_err));
            check($sformatf("vec%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d DataOut", i),  32'(dout),     32'(vecs[i].e_dout));
            model_step(vecs[i].r, vecs[i].rdv, vecs[i].wrv, vecs[i].a, vecs[i].d, 1'b0);
            next_cycle();
        end

        // Randomized traffic over a small address window so banks collide.
        r_r = 0; r_rd = 0; r_wr = 0; r_a = '0; r_d = '0;
        for (int n = 0; n < N_RAND; n++) begin
            if (!(exp_stall_last && $urandom_range(0, 3) != 0)) begin
                int op;
                op   = int'($urandom_range(0, 9));
                r_rd = (op <= 3) || (op == 8);
                r_wr = (op >= 4 && op <= 7) || (op == 8);
                r_a  = {13'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 15) == 0)};
                r_d  = 16'($urandom);
            end
            r_r = ($urandom_range(0, 63) == 0);
            drive(r_r, r_rd, r_wr, r_a, r_d);
            model_step(r_r, r_rd, r_wr, r_a, r_d, 1'b1);
            next_cycle();
        end

        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
